// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch buffer.
package fetch_pkg;

   localparam int          FETCH_W   = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

   typedef struct packed {
      logic [FETCH_W-1:0] instr;
      logic [FETCH_W-1:0] pc;
      logic [FETCH_W-1:0] pc_plus4;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular entry store with read/write pointers and occupancy count.
// Storage is not reset; only the pointers and count are.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fetch_entry_t,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  entry_t      wdata,
   output entry_t      rdata,
   output logic [AW:0] count
);

   entry_t          mem [DEPTH];
   logic   [AW-1:0] wr_ptr, rd_ptr;
   logic            push_ok, pop_ok;

   // Guard against overflow/underflow so callers cannot corrupt the count.
   assign push_ok = push && (count != (AW+1)'(DEPTH));
   assign pop_ok  = pop  && (count != '0);
   assign rdata   = mem[rd_ptr];

   // Entry write; data-only, no reset needed.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem[wr_ptr] <= wdata;
   end

   // Pointer and count update; flush wins over push/pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch-to-decode instruction queue: push/pop handshake, flush, and the
// optional same-cycle bypass enabled by macro FETCH_BUFFER_BYPASS_EN.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] PCF,
   input  logic [WIDTH-1:0] InstrF,
   input  logic             FetchValidF,
   input  logic             StallD,
   input  logic             FlushD,
   output logic             StallF,
   output logic             ValidD,
   output logic [WIDTH-1:0] InstrD,
   output logic [WIDTH-1:0] PCD,
   output logic [WIDTH-1:0] PCPlus4D
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [WIDTH-1:0] instr;
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] pc_plus4;
   } entry_t;

   entry_t        wentry, head;
   logic [AW:0]   count;
   logic          empty, push, pop;

   // PC+4 wraps naturally at 2^WIDTH.
   assign wentry = '{instr: InstrF, pc: PCF, pc_plus4: PCF + WIDTH'(4)};
   assign empty  = (count == '0);
   assign StallF = (count == (AW+1)'(DEPTH));

   // Handshake decode and output mux (NOP/zeros when nothing valid).
   always_comb begin
      push     = FetchValidF && !StallF && !FlushD;
      pop      = !empty && !StallD && !FlushD;
      ValidD   = !empty;
      InstrD   = head.instr;
      PCD      = head.pc;
      PCPlus4D = head.pc_plus4;
      if (empty) begin
         InstrD   = WIDTH'(NOP_INSTR);
         PCD      = '0;
         PCPlus4D = '0;
      end
`ifdef FETCH_BUFFER_BYPASS_EN
      // Empty queue: forward the fetch directly; store it only if decode stalls.
      if (empty && FetchValidF && !FlushD) begin
         ValidD   = 1'b1;
         InstrD   = wentry.instr;
         PCD      = wentry.pc;
         PCPlus4D = wentry.pc_plus4;
         push     = StallD;
      end
`endif
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (FlushD),
      .wdata (wentry),
      .rdata (head),
      .count (count)
   );

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the address and instruction data width.
REQ-002 Parameter DEPTH, default 4, SHALL set the queue entry count; it SHALL be a power of two, at least 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 PCF  input  WIDTH  SHALL carry the fetch address from the program counter.
REQ-006 InstrF  input  WIDTH  SHALL carry the instruction memory word for PCF.
REQ-007 FetchValidF  input  1  SHALL mark PCF/InstrF as a valid fetch this cycle.
REQ-008 StallD  input  1  SHALL indicate that decode cannot accept the head entry this cycle.
REQ-009 FlushD  input  1  SHALL indicate a taken branch or jump; all queued fetches are discarded.
REQ-010 StallF  output  1  SHALL tell the program counter to hold PCF.
REQ-011 ValidD  output  1  SHALL mark InstrD/PCD/PCPlus4D as valid.
REQ-012 InstrD, PCD, PCPlus4D  output  WIDTH each  SHALL carry the head entry to decode.

Function
REQ-013 Push SHALL occur when FetchValidF=1, count<DEPTH and FlushD=0; the entry stores {InstrF, PCF, PCF+4}.
REQ-014 PCPlus4 SHALL be computed modulo 2^WIDTH (0xFFFFFFFC+4 -> 0x00000000).
REQ-015 Pop SHALL occur when ValidD=1, StallD=0 and FlushD=0.
REQ-016 Push and pop in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-017 ValidD SHALL equal (count!=0); with ValidD=0, InstrD SHALL be 0x00000013 (NOP), and PCD and PCPlus4D SHALL be 0.
REQ-018 StallF SHALL equal (count==DEPTH), derived from registered state only.
REQ-019 With StallF=1, a fetch presented on FetchValidF SHALL be ignored, not stored; a same-cycle pop frees exactly one slot for the next cycle.
REQ-020 Default latency SHALL be one cycle: an entry pushed in cycle N first appears on ValidD/InstrD in cycle N+1.
REQ-021 FlushD=1 SHALL set count, read and write pointers to 0 at the next edge and drop any same-cycle push and pop; flush overrides everything.
REQ-022 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0; count SHALL be log2(DEPTH)+1 bits.
REQ-023 Entries SHALL be delivered in push order, and none SHALL be duplicated or lost except by flush.

Reset
REQ-024 While rst=0, count and both pointers SHALL be 0, giving ValidD=0, StallF=0 and NOP outputs.
REQ-025 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-026 Entry storage needs no reset; no output SHALL expose it while ValidD=0.

Configuration
REQ-027 With macro FETCH_BUFFER_BYPASS_EN defined, if count==0 and FetchValidF=1 and FlushD=0, the fetch SHALL appear on the outputs in the same cycle with ValidD=1.
REQ-028 Under bypass, if StallD=0 the entry SHALL be consumed without being written; if StallD=1 it SHALL be written as a normal push.
REQ-029 Without FETCH_BUFFER_BYPASS_EN, latency SHALL be exactly as in REQ-020.

Structure
REQ-030 Package fetch_pkg SHALL hold the NOP constant 0x00000013 and the packed struct fetch_entry_t {instr, pc, pc_plus4}.
REQ-031 Storage and pointer logic SHALL be one sub-module, fetch_fifo, of fetch_entry_t entries; fetch_buffer owns the handshake, flush and bypass logic.

Verification
REQ-032 Reset, then push PC=0x0/0x4/0x8 with StallD=0 -> PCD=0x0,0x4,0x8 on cycles 2,3,4; PCPlus4D=0x4,0x8,0xC.
REQ-033 StallD=1 with 5 consecutive fetches, DEPTH=4 -> StallF=1 after 4th push; 5th not stored; release StallD -> 4 entries delivered in order, StallF drops the cycle after the first pop.
REQ-034 Queue holds 3 entries and FlushD=1 with a concurrent fetch -> next cycle ValidD=0, InstrD=0x00000013, count=0.
REQ-035 PCF=0xFFFFFFFC pushed -> PCPlus4D=0x00000000.
REQ-036 rst driven low between edges while 2 entries are queued -> ValidD=0 immediately; after release, first new push is delivered correctly.
REQ-037 With FETCH_BUFFER_BYPASS_EN, empty queue, fetch of InstrF=0x00500093 -> InstrD=0x00500093, ValidD=1 in the same cycle; count stays 0 when StallD=0.
